// File: rtl/video_timing_gen.sv
// Raster timing source: signed hpos/vpos with blanking mapped to negative coordinates,
// plus registered line/frame pulses, sync, data enable and a frame counter.
module video_timing_gen #(
  parameter int HRES      = 1280,
  parameter int HFP       = 110,
  parameter int HSW       = 40,
  parameter int HBP       = 220,
  parameter int VRES      = 720,
  parameter int VFP       = 5,
  parameter int VSW       = 5,
  parameter int VBP       = 20,
  parameter int HSYNC_POL = 1,
  parameter int VSYNC_POL = 1
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  input  logic               en,
  output logic signed [11:0] hpos,
  output logic signed [11:0] vpos,
  output logic               fsync,
  output logic               lsync,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [15:0]        frame_cnt
);

  localparam int HBLK = HFP + HSW + HBP;
  localparam int VBLK = VFP + VSW + VBP;

  if (HRES + HBLK > 2047) begin : g_hchk
    $error("video_timing_gen: HRES+HBLK exceeds 2047");
  end
  if (VRES + VBLK > 2047) begin : g_vchk
    $error("video_timing_gen: VRES+VBLK exceeds 2047");
  end

  localparam logic signed [11:0] H_FIRST   = 12'(-HBLK);
  localparam logic signed [11:0] H_LAST    = 12'(HRES - 1);
  localparam logic signed [11:0] H_SYNC_LO = 12'(-HSW - HBP);
  localparam logic signed [11:0] H_SYNC_HI = 12'(-HBP - 1);
  localparam logic signed [11:0] V_FIRST   = 12'(-VBLK);
  localparam logic signed [11:0] V_LAST    = 12'(VRES - 1);
  localparam logic signed [11:0] V_SYNC_LO = 12'(-VSW - VBP);
  localparam logic signed [11:0] V_SYNC_HI = 12'(-VBP - 1);
  localparam logic               HS_ON     = 1'(HSYNC_POL);
  localparam logic               VS_ON     = 1'(VSYNC_POL);

  logic signed [11:0] hpos_nxt;
  logic signed [11:0] vpos_nxt;
  logic               lsync_nxt;
  logic               fsync_nxt;
  logic               hsync_nxt;
  logic               vsync_nxt;
  logic               de_nxt;

  // Flags are derived from the next position so they land with the coordinate they describe.
  always_comb begin
    hpos_nxt = hpos + 12'sd1;
    vpos_nxt = vpos;
    if (hpos == H_LAST) begin
      hpos_nxt = H_FIRST;
      vpos_nxt = (vpos == V_LAST) ? V_FIRST : vpos + 12'sd1;
    end
    lsync_nxt = (hpos_nxt == H_FIRST);
    fsync_nxt = lsync_nxt && (vpos_nxt == V_FIRST);
    hsync_nxt = (hpos_nxt >= H_SYNC_LO && hpos_nxt <= H_SYNC_HI) ? HS_ON : ~HS_ON;
    vsync_nxt = (vpos_nxt >= V_SYNC_LO && vpos_nxt <= V_SYNC_HI) ? VS_ON : ~VS_ON;
    de_nxt    = (hpos_nxt >= 12'sd0) && (vpos_nxt >= 12'sd0);
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos      <= H_LAST;
      vpos      <= V_LAST;
      fsync     <= 1'b0;
      lsync     <= 1'b0;
      hsync     <= ~HS_ON;
      vsync     <= ~VS_ON;
      de        <= 1'b0;
      frame_cnt <= 16'd0;
    end else if (en) begin
      hpos  <= hpos_nxt;
      vpos  <= vpos_nxt;
      fsync <= fsync_nxt;
      lsync <= lsync_nxt;
      hsync <= hsync_nxt;
      vsync <= vsync_nxt;
      de    <= de_nxt;
      if (fsync_nxt) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end else begin
      // Frozen raster: pulses drop so a held position never re-triggers downstream logic.
      fsync <= 1'b0;
      lsync <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: vector table plus a column/line-index reference model
// feeding a scoreboard queue, with hand sequences for freeze, async reset and counter wrap.
module tb_video_timing_gen;

  localparam int HRES = 8, HFP = 2, HSW = 2, HBP = 2;
  localparam int VRES = 4, VFP = 1, VSW = 1, VBP = 1;
  localparam int HBLK = HFP + HSW + HBP;
  localparam int VBLK = VFP + VSW + VBP;
  localparam int HTOT = HRES + HBLK;
  localparam int VTOT = VRES + VBLK;

  typedef struct packed {
    logic signed [11:0] hpos;
    logic signed [11:0] vpos;
    logic               fsync;
    logic               lsync;
    logic               hsync;
    logic               vsync;
    logic               de;
    logic [15:0]        fc;
  } exp_t;

  typedef struct packed {
    logic en;
    exp_t exp;
  } vec_t;

  logic               pixel_clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic signed [11:0] hpos, vpos, hpos0, vpos0;
  logic               fsync, lsync, hsync, vsync, de;
  logic               fsync0, lsync0, hsync0, vsync0, de0;
  logic [15:0]        frame_cnt, frame_cnt0;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t m;
  int   mc, mr;

  video_timing_gen #(.HRES(HRES), .HFP(HFP), .HSW(HSW), .HBP(HBP), .VRES(VRES), .VFP(VFP),
                     .VSW(VSW), .VBP(VBP), .HSYNC_POL(1), .VSYNC_POL(1)) dut (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .en(en), .hpos(hpos), .vpos(vpos), .fsync(fsync),
    .lsync(lsync), .hsync(hsync), .vsync(vsync), .de(de), .frame_cnt(frame_cnt));

  video_timing_gen #(.HRES(HRES), .HFP(HFP), .HSW(HSW), .HBP(HBP), .VRES(VRES), .VFP(VFP),
                     .VSW(VSW), .VBP(VBP), .HSYNC_POL(0), .VSYNC_POL(1)) dut0 (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .en(en), .hpos(hpos0), .vpos(vpos0), .fsync(fsync0),
    .lsync(lsync0), .hsync(hsync0), .vsync(vsync0), .de(de0), .frame_cnt(frame_cnt0));

  always #5 pixel_clk = ~pixel_clk;

  function automatic string fmt(input exp_t x);
    return $sformatf("h=%0d v=%0d fs=%b ls=%b hs=%b vs=%b de=%b fc=%0d",
                     x.hpos, x.vpos, x.fsync, x.lsync, x.hsync, x.vsync, x.de, x.fc);
  endfunction

  function automatic exp_t act_main();
    exp_t a;
    a = '{hpos, vpos, fsync, lsync, hsync, vsync, de, frame_cnt};
    return a;
  endfunction

  // Inverted-polarity instance, normalised so it should match the active-high expectation.
  function automatic exp_t act_inv();
    exp_t a;
    a = '{hpos0, vpos0, fsync0, lsync0, ~hsync0, vsync0, de0, frame_cnt0};
    return a;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mc = HTOT - 1;
    mr = VTOT - 1;
    m = '{12'(mc - HBLK), 12'(mr - VBLK), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
  endtask

  task automatic model_step(input logic e);
    if (e) begin
      mc++;
      if (mc == HTOT) begin
        mc = 0;
        mr++;
        if (mr == VTOT) mr = 0;
      end
      m.hpos  = 12'(mc - HBLK);
      m.vpos  = 12'(mr - VBLK);
      m.lsync = (mc == 0);
      m.fsync = (mc == 0) && (mr == 0);
      m.hsync = (mc >= HFP) && (mc < HFP + HSW);
      m.vsync = (mr >= VFP) && (mr < VFP + VSW);
      m.de    = (mc >= HBLK) && (mr >= VBLK);
      if (m.fsync) m.fc = m.fc + 16'd1;
    end else begin
      m.fsync = 1'b0;
      m.lsync = 1'b0;
    end
  endtask

  task automatic check_out(input string name);
    exp_t e, a;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %s", name, fmt(act_main()));
      return;
    end
    e = sb.pop_front();
    a = act_main();
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", name, fmt(a), fmt(e));
    end
    n_chk++;
    a = act_inv();
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s_pol0: got %s (hs shown inverted), expected %s", name, fmt(a), fmt(e));
    end
  endtask

  task automatic tick(input logic e, input string name);
    en = e;
    model_step(e);
    sb.push_back(m);
    @(negedge pixel_clk);
    check_out(name);
  endtask

  task automatic check_reset(input string name);
    exp_t r;
    r = '{12'(HRES - 1), 12'(VRES - 1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    n_chk++;
    if (act_main() !== r) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", name, fmt(act_main()), fmt(r));
    end
    n_chk++;
    if (act_inv() !== r) begin
      n_fail++;
      $display("FAIL %s_pol0: got %s (hs shown inverted), expected %s", name, fmt(act_inv()), fmt(r));
    end
  endtask

  task automatic do_reset();
    en    = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge pixel_clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  vec_t vecs[8];
  int   n_ls, n_de, n_vs, n_hs, bad_vs, bad_hs, n_fs, guard;

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;

    // Reset state, then the start of the first frame from a vector table.
    do_reset();
    check_reset("reset_state");
    vecs[0] = '{1'b1, '{-12'sd6, -12'sd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1}};
    vecs[1] = '{1'b1, '{-12'sd5, -12'sd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1}};
    vecs[2] = '{1'b0, '{-12'sd5, -12'sd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1}};
    vecs[3] = '{1'b1, '{-12'sd4, -12'sd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1}};
    vecs[4] = '{1'b1, '{-12'sd3, -12'sd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1}};
    vecs[5] = '{1'b1, '{-12'sd2, -12'sd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1}};
    vecs[6] = '{1'b1, '{-12'sd1, -12'sd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1}};
    vecs[7] = '{1'b1, '{ 12'sd0, -12'sd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1}};
    for (int i = 0; i < 8; i++) begin
      en = vecs[i].en;
      model_step(vecs[i].en);
      sb.push_back(vecs[i].exp);
      @(negedge pixel_clk);
      check_out($sformatf("vec%0d", i));
    end

    // One full frame from the first fsync, tallying flags.
    do_reset();
    tick(1'b1, "first_edge");
    n_ls = int'(lsync); n_de = int'(de); n_vs = int'(vsync); n_hs = int'(hsync);
    bad_vs = 0; bad_hs = 0;
    for (int i = 1; i < HTOT * VTOT; i++) begin
      tick(1'b1, "frame_run");
      n_ls += int'(lsync); n_de += int'(de); n_vs += int'(vsync); n_hs += int'(hsync);
      if (vsync && vpos != -12'sd2) bad_vs++;
      if (hsync && hpos != -12'sd4 && hpos != -12'sd3) bad_hs++;
    end
    tick(1'b1, "second_fsync");
    chk("fsync_after_98", int'(fsync), 1);
    chk("frame_cnt_after_98", int'(frame_cnt), 2);
    chk("lsync_per_frame", n_ls, 7);
    chk("de_per_frame", n_de, 32);
    chk("vsync_per_frame", n_vs, 14);
    chk("hsync_per_frame", n_hs, 14);
    chk("vsync_outside_vpos_m2", bad_vs, 0);
    chk("hsync_outside_window", bad_hs, 0);

    // Freeze right after fsync: no re-pulse, position and count held, resume at -5.
    n_fs = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, "freeze");
      n_fs += int'(fsync);
    end
    chk("freeze_fsync_pulses", n_fs, 0);
    chk("freeze_hpos", int'(hpos), -6);
    chk("freeze_frame_cnt", int'(frame_cnt), 2);
    tick(1'b1, "resume");
    chk("resume_hpos", int'(hpos), -5);

    // Asynchronous reset mid-frame at (3,1).
    guard = 0;
    while (!(hpos == 12'sd3 && vpos == 12'sd1) && guard < 200) begin
      tick(1'b1, "seek_3_1");
      guard++;
    end
    chk("seek_3_1_timeout", guard < 200 ? 1 : 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_reset");
    @(negedge pixel_clk);
    rst_n = 1'b1;
    model_reset();
    sb.delete();

    // Counter wrap: preload 16'hFFFF while frozen, then the next fsync wraps to 0.
    force dut.frame_cnt  = 16'hFFFF;
    force dut0.frame_cnt = 16'hFFFF;
    m.fc = 16'hFFFF;
    tick(1'b0, "preload");
    release dut.frame_cnt;
    release dut0.frame_cnt;
    #1;
    chk("preload_held", int'(frame_cnt), 16'hFFFF);
    guard = 0;
    do begin
      tick(1'b1, "run_to_wrap");
      guard++;
    end while (!fsync && guard < 200);
    chk("wrap_fsync_seen", int'(fsync), 1);
    chk("frame_cnt_wrap", int'(frame_cnt), 0);
    chk("frame_cnt0_wrap", int'(frame_cnt0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
